issue_dispatch_unit: RTL and testbench
======================================

Name: issue_dispatch_unit

Overview:
- Sits directly downstream of the instruction queue in the Tomasulo core.
- Accepts up to two decoded instructions per cycle and allocates ADD/MUL reservation-station (RS) entries for them.
- Renames operands through an internal register status table (RAT) and an architectural register file.
- Drives the queue's select_instruction advance code back to it.

Parameters:
- NUM_REGS, 32, architectural registers; register specifier uses bits [4:0] of the 8-bit field.
- NUM_ADD_RS, 3, ADD reservation stations, tags 1..3.
- NUM_MUL_RS, 2, MUL reservation stations, tags 4..5.
- DATA_W, 32, operand width.
- TAG_W, 3, RS tag width; tag 0 = "value ready".

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- inst1_valid  in  1  slot-0 instruction present.
- inst1_type/inst1_destination_reg/inst1_source_reg1/inst1_source_reg2  in  8 each  slot-0 fields.
- inst2_valid  in  1  slot-1 instruction present.
- inst2_type/inst2_destination_reg/inst2_source_reg1/inst2_source_reg2  in  8 each  slot-1 fields.
- select_instruction  out  2  00 none consumed, 01 slot 0 consumed, 10 both consumed; combinational.
- rs_release  in  NUM_ADD_RS+NUM_MUL_RS  one-hot-per-entry free pulse; bit i = tag i+1.
- cdb_valid  in  1  common data bus broadcast.
- cdb_tag  in  TAG_W  producing RS tag.
- cdb_value  in  DATA_W  result.
- issueN_valid  out  1  slot N issued (N=0,1); registered.
- issueN_tag  out  TAG_W  allocated RS tag.
- issueN_op  out  8  instruction type.
- issueN_vj/issueN_vk  out  DATA_W  operand values; valid when the matching q is 0.
- issueN_qj/issueN_qk  out  TAG_W  pending producer tags.

Behaviour:
Reset:
- busy bits, RAT and all issue outputs are cleared to 0.
- regfile[i] = i.
- select_instruction = 00 while reset is high.
- Reset mid-operation discards all in-flight allocations.

Issue rules:
- Slot 0 issues if inst1_valid and a free RS of its class exists.
- Slot 1 issues only if slot 0 issues, inst2_valid is high, and a second free entry of its class remains after slot 0's allocation. Issue is strictly in order.
- Free entries are taken from busy bits as registered at the start of the cycle. A same-cycle rs_release does not make an entry allocatable until the next cycle. Release of a non-busy entry is ignored.
- Allocation picks the lowest-index free entry of the class. Two same-class issues take the two lowest.
- Type neither ADD nor MUL: the slot is consumed (counts in select_instruction) with no allocation, no RAT update and issueN_valid=0.

Operand read (per source):
- If RAT[src]==0: v=regfile[src], q=0.
- Else if cdb_valid && cdb_tag==RAT[src]: v=cdb_value, q=0 (same-cycle bypass).
- Else q=RAT[src].
- Slot 1 sources matching slot 0's dest take q=slot 0 tag; this overrides RAT and the bypass.

Latency and outputs:
- Issue outputs are registered: instructions presented in cycle N appear on issue ports in cycle N+1 for exactly one cycle.

State update at the clock edge:
- CDB: every register with RAT==cdb_tag gets regfile=cdb_value and RAT=0.
- Issue: RAT[dest]=new tag; busy set for the allocated entry.
- An issue write to RAT[dest] wins over a same-cycle CDB clear.
- Both slots with the same dest: slot 1's tag wins.
- An instruction whose sources equal its own dest reads the old mapping.

Decomposition:
- Shared definitions file: opcode constants ADD/MUL, register constants R0..R31, tag ranges, the select_instruction encodings.
- One sub-module, rs_allocator: given busy vector and class, returns first and second free index plus found flags.

Test Plan:
- After reset, ADD R5,R3,R4 in slot 0 only -> select=01; next cycle issue0 tag=1, vj=3, vk=4, qj=qk=0.
- MUL R2,R0,R1 in slot 0 plus ADD R8,R2,R7 in slot 1 -> select=10; issue1 qj=4, vk=7.
- Four ADDs over two cycles with no release -> 3 allocations (tags 1,2,3), then select=00 until rs_release bit0 pulses; tag 1 is reallocated the cycle after the pulse.
- RAT[R2]=4 with cdb_valid, tag 4, value 99 in the same cycle ADD R9,R2,R2 issues -> vj=vk=99, qj=qk=0; regfile[R2]=99 next cycle.
- Both slots with dest R10 (ADD then MUL) -> RAT[R10]=4; a later CDB on tag 1 leaves R10 unchanged.
- Reset asserted mid-stream -> select=00, busy and RAT cleared, issue valids 0 the next cycle.

Source files
------------

// File: rtl/issue_dispatch_unit_pkg.sv
// Shared definitions for the issue/dispatch stage: opcodes, register names,
// RS tag ranges, select encodings and the issue-port bundle.
package issue_dispatch_unit_pkg;

  localparam int NUM_REGS   = 32;
  localparam int NUM_ADD_RS = 3;
  localparam int NUM_MUL_RS = 2;
  localparam int NUM_RS     = NUM_ADD_RS + NUM_MUL_RS;
  localparam int DATA_W     = 32;
  localparam int TAG_W      = 3;
  localparam int REG_IDX_W  = 5;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_MUL = 8'h02;

  localparam logic [7:0] R0  = 8'd0,  R1  = 8'd1,  R2  = 8'd2,  R3  = 8'd3;
  localparam logic [7:0] R4  = 8'd4,  R5  = 8'd5,  R6  = 8'd6,  R7  = 8'd7;
  localparam logic [7:0] R8  = 8'd8,  R9  = 8'd9,  R10 = 8'd10, R11 = 8'd11;
  localparam logic [7:0] R12 = 8'd12, R13 = 8'd13, R14 = 8'd14, R15 = 8'd15;
  localparam logic [7:0] R16 = 8'd16, R17 = 8'd17, R18 = 8'd18, R19 = 8'd19;
  localparam logic [7:0] R20 = 8'd20, R21 = 8'd21, R22 = 8'd22, R23 = 8'd23;
  localparam logic [7:0] R24 = 8'd24, R25 = 8'd25, R26 = 8'd26, R27 = 8'd27;
  localparam logic [7:0] R28 = 8'd28, R29 = 8'd29, R30 = 8'd30, R31 = 8'd31;

  localparam logic [TAG_W-1:0] TAG_READY  = 3'd0;
  localparam logic [TAG_W-1:0] ADD_TAG_LO = 3'd1;
  localparam logic [TAG_W-1:0] ADD_TAG_HI = 3'd3;
  localparam logic [TAG_W-1:0] MUL_TAG_LO = 3'd4;
  localparam logic [TAG_W-1:0] MUL_TAG_HI = 3'd5;

  localparam logic [1:0] SEL_NONE  = 2'b00;
  localparam logic [1:0] SEL_SLOT0 = 2'b01;
  localparam logic [1:0] SEL_BOTH  = 2'b10;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_ADD  = 2'd1,
    CLS_MUL  = 2'd2
  } rs_class_e;

  typedef struct packed {
    logic [DATA_W-1:0] v;
    logic [TAG_W-1:0]  q;
  } operand_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [7:0]        op;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
  } issue_t;

  function automatic rs_class_e op_class(input logic [7:0] op);
    case (op)
      OP_ADD:  return CLS_ADD;
      OP_MUL:  return CLS_MUL;
      default: return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/issue_dispatch_unit_rs_allocator.sv
// Finds the two lowest-index free reservation stations of one class.
// Indices are entry numbers (tag - 1).
module issue_dispatch_unit_rs_allocator
  import issue_dispatch_unit_pkg::*;
(
  input  logic [NUM_RS-1:0] busy,
  input  rs_class_e         rs_class,
  output logic [TAG_W-1:0]  first_idx,
  output logic [TAG_W-1:0]  second_idx,
  output logic              first_found,
  output logic              second_found
);

  logic cand_s;
  logic in_class_s;

  // Priority scan from the lowest entry of the class upward
  always_comb begin
    first_idx    = 3'd0;
    second_idx   = 3'd0;
    first_found  = 1'b0;
    second_found = 1'b0;
    cand_s       = 1'b0;
    in_class_s   = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      in_class_s   = ((rs_class == CLS_ADD) && (i < NUM_ADD_RS)) ||
                     ((rs_class == CLS_MUL) && (i >= NUM_ADD_RS));
      cand_s       = in_class_s && !busy[i];
      second_idx   = (cand_s && first_found && !second_found) ? TAG_W'(i) : second_idx;
      second_found = second_found || (cand_s && first_found);
      first_idx    = (cand_s && !first_found) ? TAG_W'(i) : first_idx;
      first_found  = first_found || cand_s;
    end
  end

endmodule

// File: rtl/issue_dispatch_unit.sv
// Dual-slot in-order issue stage: allocates ADD/MUL reservation stations,
// renames operands through the RAT with CDB bypass, registers issue ports.
module issue_dispatch_unit
  import issue_dispatch_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst1_valid,
  input  logic [7:0]            inst1_type,
  input  logic [7:0]            inst1_destination_reg,
  input  logic [7:0]            inst1_source_reg1,
  input  logic [7:0]            inst1_source_reg2,
  input  logic                  inst2_valid,
  input  logic [7:0]            inst2_type,
  input  logic [7:0]            inst2_destination_reg,
  input  logic [7:0]            inst2_source_reg1,
  input  logic [7:0]            inst2_source_reg2,
  output logic [1:0]            select_instruction,
  input  logic [NUM_RS-1:0]     rs_release,
  input  logic                  cdb_valid,
  input  logic [TAG_W-1:0]      cdb_tag,
  input  logic [DATA_W-1:0]     cdb_value,
  output logic                  issue0_valid,
  output logic [TAG_W-1:0]      issue0_tag,
  output logic [7:0]            issue0_op,
  output logic [DATA_W-1:0]     issue0_vj,
  output logic [DATA_W-1:0]     issue0_vk,
  output logic [TAG_W-1:0]      issue0_qj,
  output logic [TAG_W-1:0]      issue0_qk,
  output logic                  issue1_valid,
  output logic [TAG_W-1:0]      issue1_tag,
  output logic [7:0]            issue1_op,
  output logic [DATA_W-1:0]     issue1_vj,
  output logic [DATA_W-1:0]     issue1_vk,
  output logic [TAG_W-1:0]      issue1_qj,
  output logic [TAG_W-1:0]      issue1_qk
);

  logic [NUM_RS-1:0] busy_q, busy_d, alloc_vec;
  logic [TAG_W-1:0]  rat_q [NUM_REGS];
  logic [TAG_W-1:0]  rat_d [NUM_REGS];
  logic [DATA_W-1:0] regfile_q [NUM_REGS];
  logic [DATA_W-1:0] regfile_d [NUM_REGS];
  issue_t            issue0_q, issue0_d, issue1_q, issue1_d;

  rs_class_e         cls0, cls1;
  logic [TAG_W-1:0]  a0_first, a0_second, a1_first, a1_second;
  logic              a0_ff, a0_sf, a1_ff, a1_sf;
  logic              same_cls, ok1, take0, take1, alloc0, alloc1, cdb_hit;
  logic [TAG_W-1:0]  idx1, tag0, tag1;
  logic [REG_IDX_W-1:0] d0, d1;
  operand_t          op0j, op0k, op1j, op1k;
  logic              unused_bits;

  function automatic operand_t read_operand(
    input logic [TAG_W-1:0]  rat_tag,
    input logic [DATA_W-1:0] reg_val,
    input logic              cdb_v,
    input logic [TAG_W-1:0]  cdb_t,
    input logic [DATA_W-1:0] cdb_d
  );
    operand_t r;
    if (rat_tag == TAG_READY) begin
      r.v = reg_val;
      r.q = TAG_READY;
    end else if (cdb_v && (cdb_t == rat_tag)) begin
      r.v = cdb_d;
      r.q = TAG_READY;
    end else begin
      r.v = {DATA_W{1'b0}};
      r.q = rat_tag;
    end
    return r;
  endfunction

  assign cls0 = op_class(inst1_type);
  assign cls1 = op_class(inst2_type);
  assign d0   = inst1_destination_reg[REG_IDX_W-1:0];
  assign d1   = inst2_destination_reg[REG_IDX_W-1:0];

  issue_dispatch_unit_rs_allocator u_alloc0 (
    .busy(busy_q), .rs_class(cls0),
    .first_idx(a0_first), .second_idx(a0_second),
    .first_found(a0_ff), .second_found(a0_sf)
  );

  issue_dispatch_unit_rs_allocator u_alloc1 (
    .busy(busy_q), .rs_class(cls1),
    .first_idx(a1_first), .second_idx(a1_second),
    .first_found(a1_ff), .second_found(a1_sf)
  );

  // Slot acceptance, operand renaming and next issue-port contents
  always_comb begin
    same_cls = (cls1 == cls0);
    ok1      = same_cls ? a1_sf : a1_ff;
    idx1     = same_cls ? a1_second : a1_first;
    take0    = inst1_valid && ((cls0 == CLS_NONE) || a0_ff);
    alloc0   = take0 && (cls0 != CLS_NONE);
    take1    = take0 && inst2_valid && ((cls1 == CLS_NONE) || ok1);
    alloc1   = take1 && (cls1 != CLS_NONE);
    tag0     = a0_first + 3'd1;
    tag1     = idx1 + 3'd1;

    op0j = read_operand(rat_q[inst1_source_reg1[4:0]], regfile_q[inst1_source_reg1[4:0]],
                        cdb_valid, cdb_tag, cdb_value);
    op0k = read_operand(rat_q[inst1_source_reg2[4:0]], regfile_q[inst1_source_reg2[4:0]],
                        cdb_valid, cdb_tag, cdb_value);
    op1j = read_operand(rat_q[inst2_source_reg1[4:0]], regfile_q[inst2_source_reg1[4:0]],
                        cdb_valid, cdb_tag, cdb_value);
    op1k = read_operand(rat_q[inst2_source_reg2[4:0]], regfile_q[inst2_source_reg2[4:0]],
                        cdb_valid, cdb_tag, cdb_value);
    // Slot 1 depends on slot 0's fresh result, which no RAT/CDB path knows yet
    op1j = (alloc0 && (inst2_source_reg1[4:0] == d0)) ? {{DATA_W{1'b0}}, tag0} : op1j;
    op1k = (alloc0 && (inst2_source_reg2[4:0] == d0)) ? {{DATA_W{1'b0}}, tag0} : op1k;

    if (reset) begin
      select_instruction = SEL_NONE;
    end else if (take1) begin
      select_instruction = SEL_BOTH;
    end else if (take0) begin
      select_instruction = SEL_SLOT0;
    end else begin
      select_instruction = SEL_NONE;
    end

    issue0_d = {alloc0, tag0, inst1_type, op0j.v, op0k.v, op0j.q, op0k.q};
    issue1_d = {alloc1, tag1, inst2_type, op1j.v, op1k.v, op1j.q, op1k.q};
  end

  // Next busy vector, CDB writeback and RAT rename (slot 1 written last)
  always_comb begin
    alloc_vec = (NUM_RS'(alloc0) << a0_first) | (NUM_RS'(alloc1) << idx1);
    busy_d    = (busy_q & ~rs_release) | alloc_vec;
    cdb_hit   = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cdb_hit      = cdb_valid && (cdb_tag != TAG_READY) && (rat_q[r] == cdb_tag);
      rat_d[r]     = cdb_hit ? TAG_READY : rat_q[r];
      regfile_d[r] = cdb_hit ? cdb_value : regfile_q[r];
    end
    rat_d[d0] = alloc0 ? tag0 : rat_d[d0];
    rat_d[d1] = alloc1 ? tag1 : rat_d[d1];
  end

  // State and issue-port registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= {NUM_RS{1'b0}};
      issue0_q <= '0;
      issue1_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        rat_q[r]     <= TAG_READY;
        regfile_q[r] <= DATA_W'(r);
      end
    end else begin
      busy_q    <= busy_d;
      issue0_q  <= issue0_d;
      issue1_q  <= issue1_d;
      rat_q     <= rat_d;
      regfile_q <= regfile_d;
    end
  end

  assign issue0_valid = issue0_q.valid;
  assign issue0_tag   = issue0_q.tag;
  assign issue0_op    = issue0_q.op;
  assign issue0_vj    = issue0_q.vj;
  assign issue0_vk    = issue0_q.vk;
  assign issue0_qj    = issue0_q.qj;
  assign issue0_qk    = issue0_q.qk;
  assign issue1_valid = issue1_q.valid;
  assign issue1_tag   = issue1_q.tag;
  assign issue1_op    = issue1_q.op;
  assign issue1_vj    = issue1_q.vj;
  assign issue1_vk    = issue1_q.vk;
  assign issue1_qj    = issue1_q.qj;
  assign issue1_qk    = issue1_q.qk;

  assign unused_bits = ^{inst1_destination_reg[7:5], inst1_source_reg1[7:5], inst1_source_reg2[7:5],
                         inst2_destination_reg[7:5], inst2_source_reg1[7:5], inst2_source_reg2[7:5],
                         a0_second, a0_sf};

endmodule

// File: tb/tb_issue_dispatch_unit.sv
// Directed plus randomized bench for issue_dispatch_unit against a queue-based
// reference model of the RS pool, RAT and register file.
module tb_issue_dispatch_unit;
  import issue_dispatch_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic inst1_valid, inst2_valid;
  logic [7:0] inst1_type, inst1_destination_reg, inst1_source_reg1, inst1_source_reg2;
  logic [7:0] inst2_type, inst2_destination_reg, inst2_source_reg1, inst2_source_reg2;
  logic [1:0] select_instruction;
  logic [4:0] rs_release;
  logic cdb_valid;
  logic [2:0] cdb_tag;
  logic [31:0] cdb_value;
  logic issue0_valid, issue1_valid;
  logic [2:0] issue0_tag, issue0_qj, issue0_qk, issue1_tag, issue1_qj, issue1_qk;
  logic [7:0] issue0_op, issue1_op;
  logic [31:0] issue0_vj, issue0_vk, issue1_vj, issue1_vk;

  issue_dispatch_unit dut (
    .clk(clk), .reset(reset),
    .inst1_valid(inst1_valid), .inst1_type(inst1_type), .inst1_destination_reg(inst1_destination_reg),
    .inst1_source_reg1(inst1_source_reg1), .inst1_source_reg2(inst1_source_reg2),
    .inst2_valid(inst2_valid), .inst2_type(inst2_type), .inst2_destination_reg(inst2_destination_reg),
    .inst2_source_reg1(inst2_source_reg1), .inst2_source_reg2(inst2_source_reg2),
    .select_instruction(select_instruction), .rs_release(rs_release),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue0_valid(issue0_valid), .issue0_tag(issue0_tag), .issue0_op(issue0_op),
    .issue0_vj(issue0_vj), .issue0_vk(issue0_vk), .issue0_qj(issue0_qj), .issue0_qk(issue0_qk),
    .issue1_valid(issue1_valid), .issue1_tag(issue1_tag), .issue1_op(issue1_op),
    .issue1_vj(issue1_vj), .issue1_vk(issue1_vk), .issue1_qj(issue1_qj), .issue1_qk(issue1_qk)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: current and next architectural state, plus expected ports
  bit          m_busy [1:5];
  int          m_rat  [32];
  logic [31:0] m_reg  [32];
  bit          n_busy [1:5];
  int          n_rat  [32];
  logic [31:0] n_reg  [32];
  bit          e_valid [2], p_valid [2];
  int          e_tag [2], e_qj [2], e_qk [2], p_tag [2], p_qj [2], p_qk [2];
  logic [7:0]  e_op [2], p_op [2];
  logic [31:0] e_vj [2], e_vk [2], p_vj [2], p_vk [2];
  int          exp_sel;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cls_of(input logic [7:0] t);
    if (t == OP_ADD) return 1;
    if (t == OP_MUL) return 2;
    return 0;
  endfunction

  task automatic read_op(input logic [7:0] src, input int slot, input int t0, input logic [7:0] d0,
                         output logic [31:0] v, output int q);
    int s;
    s = int'(src[4:0]);
    v = 32'd0;
    q = 0;
    if (slot == 1 && t0 != 0 && s == int'(d0[4:0])) q = t0;
    else if (m_rat[s] == 0) v = m_reg[s];
    else if (cdb_valid && int'(cdb_tag) == m_rat[s]) v = cdb_value;
    else q = m_rat[s];
  endtask

  task automatic model_eval();
    int fa[$], fm[$];
    int t[2];
    bit took[2], vld[2];
    logic [7:0] typ[2], dst[2], s1[2], s2[2];
    int c;
    vld = '{inst1_valid, inst2_valid};
    typ = '{inst1_type, inst2_type};
    dst = '{inst1_destination_reg, inst2_destination_reg};
    s1  = '{inst1_source_reg1, inst2_source_reg1};
    s2  = '{inst1_source_reg2, inst2_source_reg2};
    t = '{0, 0};
    took = '{1'b0, 1'b0};
    if (reset) begin
      exp_sel = 0;
      for (int e = 1; e <= 5; e++) n_busy[e] = 1'b0;
      for (int r = 0; r < 32; r++) begin n_rat[r] = 0; n_reg[r] = 32'(r); end
      for (int k = 0; k < 2; k++) begin
        p_valid[k] = 1'b0; p_tag[k] = 0; p_op[k] = 8'd0; p_vj[k] = 32'd0;
        p_vk[k] = 32'd0; p_qj[k] = 0; p_qk[k] = 0;
      end
      return;
    end
    for (int e = 1; e <= 3; e++) if (!m_busy[e]) fa.push_back(e);
    for (int e = 4; e <= 5; e++) if (!m_busy[e]) fm.push_back(e);
    for (int k = 0; k < 2; k++) begin
      if (k == 0 ? vld[0] : (took[0] && vld[1])) begin
        c = cls_of(typ[k]);
        if (c == 0) took[k] = 1'b1;
        else if (c == 1 && fa.size() > 0) begin t[k] = fa.pop_front(); took[k] = 1'b1; end
        else if (c == 2 && fm.size() > 0) begin t[k] = fm.pop_front(); took[k] = 1'b1; end
      end
    end
    exp_sel = took[1] ? 2 : (took[0] ? 1 : 0);
    for (int k = 0; k < 2; k++) begin
      p_valid[k] = (t[k] != 0);
      p_tag[k]   = t[k];
      p_op[k]    = typ[k];
      read_op(s1[k], k, t[0], dst[0], p_vj[k], p_qj[k]);
      read_op(s2[k], k, t[0], dst[0], p_vk[k], p_qk[k]);
    end
    for (int r = 0; r < 32; r++) begin
      n_rat[r] = m_rat[r];
      n_reg[r] = m_reg[r];
      if (cdb_valid && cdb_tag != 3'd0 && m_rat[r] == int'(cdb_tag)) begin
        n_rat[r] = 0;
        n_reg[r] = cdb_value;
      end
    end
    for (int e = 1; e <= 5; e++) n_busy[e] = m_busy[e] && !rs_release[e-1];
    for (int k = 0; k < 2; k++) begin
      if (t[k] != 0) begin
        n_busy[t[k]] = 1'b1;
        n_rat[int'(dst[k][4:0])] = t[k];
      end
    end
  endtask

  task automatic chk_slot(input int k, input logic v, input logic [2:0] tg, input logic [7:0] op,
                          input logic [31:0] vj, input logic [31:0] vk,
                          input logic [2:0] qj, input logic [2:0] qk);
    chk($sformatf("issue%0d_valid", k), 64'(v), 64'(e_valid[k]));
    if (e_valid[k]) begin
      chk($sformatf("issue%0d_tag", k), 64'(tg), 64'(e_tag[k]));
      chk($sformatf("issue%0d_op", k), 64'(op), 64'(e_op[k]));
      chk($sformatf("issue%0d_qj", k), 64'(qj), 64'(e_qj[k]));
      chk($sformatf("issue%0d_qk", k), 64'(qk), 64'(e_qk[k]));
      if (e_qj[k] == 0) chk($sformatf("issue%0d_vj", k), 64'(vj), 64'(e_vj[k]));
      if (e_qk[k] == 0) chk($sformatf("issue%0d_vk", k), 64'(vk), 64'(e_vk[k]));
    end
  endtask

  // One clock: check select mid-cycle, commit model at the edge, check issue ports after
  task automatic cycle();
    #1;
    model_eval();
    chk("select", 64'(select_instruction), 64'(exp_sel));
    @(posedge clk);
    m_busy = n_busy; m_rat = n_rat; m_reg = n_reg;
    e_valid = p_valid; e_tag = p_tag; e_op = p_op; e_vj = p_vj; e_vk = p_vk; e_qj = p_qj; e_qk = p_qk;
    @(negedge clk);
    chk_slot(0, issue0_valid, issue0_tag, issue0_op, issue0_vj, issue0_vk, issue0_qj, issue0_qk);
    chk_slot(1, issue1_valid, issue1_tag, issue1_op, issue1_vj, issue1_vk, issue1_qj, issue1_qk);
  endtask

  task automatic idle();
    inst1_valid = 1'b0; inst2_valid = 1'b0;
    inst1_type = 8'd0; inst1_destination_reg = 8'd0; inst1_source_reg1 = 8'd0; inst1_source_reg2 = 8'd0;
    inst2_type = 8'd0; inst2_destination_reg = 8'd0; inst2_source_reg1 = 8'd0; inst2_source_reg2 = 8'd0;
    rs_release = 5'd0; cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_value = 32'd0;
  endtask

  task automatic slot0(input logic [7:0] t, input logic [7:0] d, input logic [7:0] a, input logic [7:0] b);
    inst1_valid = 1'b1; inst1_type = t; inst1_destination_reg = d;
    inst1_source_reg1 = a; inst1_source_reg2 = b;
  endtask

  task automatic slot1(input logic [7:0] t, input logic [7:0] d, input logic [7:0] a, input logic [7:0] b);
    inst2_valid = 1'b1; inst2_type = t; inst2_destination_reg = d;
    inst2_source_reg1 = a; inst2_source_reg2 = b;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; cycle(); reset = 1'b0;
  endtask

  function automatic logic [7:0] rand_type();
    int r;
    r = $urandom_range(0, 4);
    if (r < 2) return OP_ADD;
    if (r < 4) return OP_MUL;
    return 8'($urandom_range(3, 255));
  endfunction

  task automatic rand_inputs();
    inst1_valid = ($urandom_range(0, 3) != 0);
    inst1_type = rand_type(); inst1_destination_reg = 8'($urandom);
    inst1_source_reg1 = 8'($urandom); inst1_source_reg2 = 8'($urandom);
    inst2_valid = ($urandom_range(0, 3) != 0);
    inst2_type = rand_type(); inst2_destination_reg = 8'($urandom);
    inst2_source_reg1 = 8'($urandom); inst2_source_reg2 = 8'($urandom);
    for (int i = 0; i < 5; i++) rs_release[i] = ($urandom_range(0, 2) == 0);
    cdb_valid = ($urandom_range(0, 1) == 1);
    cdb_tag = 3'($urandom_range(1, 5));
    cdb_value = $urandom;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    do_reset();
    chk("reset_valid0", 64'(issue0_valid), 64'(0));
    chk("reset_valid1", 64'(issue1_valid), 64'(0));

    // ADD R5,R3,R4 alone
    slot0(OP_ADD, R5, R3, R4);
    #1 chk("t1_select", 64'(select_instruction), 64'(1));
    cycle(); idle();
    chk("t1_tag", 64'(issue0_tag), 64'(1));
    chk("t1_vj", 64'(issue0_vj), 64'(3));
    chk("t1_vk", 64'(issue0_vk), 64'(4));
    chk("t1_q", 64'({issue0_qj, issue0_qk}), 64'(0));

    // MUL R2,R0,R1 then dependent ADD R8,R2,R7
    do_reset();
    slot0(OP_MUL, R2, R0, R1); slot1(OP_ADD, R8, R2, R7);
    #1 chk("t2_select", 64'(select_instruction), 64'(2));
    cycle(); idle();
    chk("t2_tag0", 64'(issue0_tag), 64'(4));
    chk("t2_tag1", 64'(issue1_tag), 64'(1));
    chk("t2_qj1", 64'(issue1_qj), 64'(4));
    chk("t2_vk1", 64'(issue1_vk), 64'(7));

    // ADD pool exhaustion and reuse after release
    do_reset();
    slot0(OP_ADD, R1, R2, R3); slot1(OP_ADD, R4, R5, R6); cycle();
    slot0(OP_ADD, R7, R8, R9); slot1(OP_ADD, R10, R11, R12);
    #1 chk("t3_partial_sel", 64'(select_instruction), 64'(1));
    cycle();
    chk("t3_tag3", 64'(issue0_tag), 64'(3));
    chk("t3_no_slot1", 64'(issue1_valid), 64'(0));
    idle(); slot0(OP_ADD, R13, R1, R1);
    #1 chk("t3_full_sel", 64'(select_instruction), 64'(0));
    cycle();
    rs_release = 5'b00001;
    #1 chk("t3_release_sel", 64'(select_instruction), 64'(0));
    cycle();
    rs_release = 5'd0;
    cycle(); idle();
    chk("t3_reuse_tag", 64'(issue0_tag), 64'(1));

    // Same-cycle CDB bypass and register-file writeback
    do_reset();
    slot0(OP_MUL, R2, R0, R1); cycle(); idle();
    slot0(OP_ADD, R9, R2, R2); cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_value = 32'd99;
    cycle(); idle();
    chk("t4_vj", 64'(issue0_vj), 64'(99));
    chk("t4_vk", 64'(issue0_vk), 64'(99));
    chk("t4_q", 64'({issue0_qj, issue0_qk}), 64'(0));
    slot0(OP_ADD, R11, R2, R0); cycle(); idle();
    chk("t4_regfile", 64'(issue0_vj), 64'(99));

    // Same destination in both slots: slot 1 mapping wins
    do_reset();
    slot0(OP_ADD, R10, R1, R1); slot1(OP_MUL, R10, R1, R1); cycle(); idle();
    cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_value = 32'd55; cycle(); idle();
    slot0(OP_ADD, R12, R10, R3); cycle(); idle();
    chk("t5_qj", 64'(issue0_qj), 64'(4));

    // Reset in the middle of traffic
    for (int i = 0; i < 6; i++) begin rand_inputs(); cycle(); end
    rand_inputs(); reset = 1'b1;
    #1 chk("t6_sel_in_reset", 64'(select_instruction), 64'(0));
    cycle(); reset = 1'b0; idle();
    chk("t6_valid0", 64'(issue0_valid), 64'(0));
    chk("t6_valid1", 64'(issue1_valid), 64'(0));
    slot0(OP_MUL, R3, R3, R3); cycle(); idle();
    chk("t6_mul_tag", 64'(issue0_tag), 64'(4));
    chk("t6_rat_clear", 64'(issue0_vj), 64'(3));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0; idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
